// File: rtl/branch_seq_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_seq_ctrl_pkg                                                        |
// | Shared types and constants for the PA-RISC branch sequencing controller.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package branch_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REDIR = 2'd1,
        S_NULL  = 2'd2,
        S_PEND  = 2'd3
    } state_t;

    // Condition selects; a COMB with COMB_TF=1 branches when the condition is false
    localparam logic [2:0] C_NEVER = 3'b000;
    localparam logic [2:0] C_EQ    = 3'b001;  // Z
    localparam logic [2:0] C_LT    = 3'b010;  // N != V
    localparam logic [2:0] C_LE    = 3'b011;  // Z | (N != V)
    localparam logic [2:0] C_LTU   = 3'b100;  // !C (borrow)
    localparam logic [2:0] C_LEU   = 3'b101;  // !C | Z
    localparam logic [2:0] C_SV    = 3'b110;  // V
    localparam logic [2:0] C_NEG   = 3'b111;  // N

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage
`default_nettype wire

// File: rtl/branch_seq_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_seq_ctrl_if                                                         |
// | EX-stage branch information in, PC-mux redirect / squash controls out.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface branch_seq_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              br_valid;
    logic              BL;
    logic              COMB;
    logic              COMB_TF;
    logic [2:0]        C;
    logic [3:0]        ACC;
    logic              n_bit;
    logic              br_backward;
    logic [ADDR_W-1:0] br_target;
    logic              pc_sel;
    logic [ADDR_W-1:0] redirect_pc;
    logic              flush_if;
    logic              nullify_ds;

    modport master (
        output br_valid, BL, COMB, COMB_TF, C, ACC, n_bit, br_backward, br_target,
        input  pc_sel, redirect_pc, flush_if, nullify_ds
    );

    modport slave (
        input  br_valid, BL, COMB, COMB_TF, C, ACC, n_bit, br_backward, br_target,
        output pc_sel, redirect_pc, flush_if, nullify_ds
    );
endinterface
`default_nettype wire

// File: rtl/branch_seq_ctrl_ch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_seq_ctrl_ch                                                         |
// | Condition handler: resolves the taken flag J from C/ACC, BL and COMB.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module branch_seq_ctrl_ch
    import branch_seq_ctrl_pkg::*;
(
    input  wire logic       i_bl,
    input  wire logic       i_comb,
    input  wire logic       i_comb_tf,
    input  wire logic [2:0] i_cond,
    input  wire logic [3:0] i_acc,
    output logic            o_j
);
    logic w_cond;

    always_comb begin
        w_cond = 1'b0;
        case (i_cond)
            C_NEVER: w_cond = 1'b0;
            C_EQ:    w_cond = i_acc[FLAG_Z];
            C_LT:    w_cond = i_acc[FLAG_N] ^ i_acc[FLAG_V];
            C_LE:    w_cond = i_acc[FLAG_Z] | (i_acc[FLAG_N] ^ i_acc[FLAG_V]);
            C_LTU:   w_cond = ~i_acc[FLAG_C];
            C_LEU:   w_cond = ~i_acc[FLAG_C] | i_acc[FLAG_Z];
            C_SV:    w_cond = i_acc[FLAG_V];
            C_NEG:   w_cond = i_acc[FLAG_N];
            default: w_cond = 1'b0;
        endcase
    end

    assign o_j = i_bl | (i_comb & (w_cond ^ i_comb_tf));

endmodule
`default_nettype wire

// File: rtl/branch_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_seq_ctrl                                                            |
// | Branch sequencer: PC redirect, IF flush, delay-slot nullify, stats.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module branch_seq_ctrl
    import branch_seq_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         stall,
    branch_seq_ctrl_if.slave  bus,
    output logic              busy,
    output logic [CNT_W-1:0]  taken_cnt,
    output logic [CNT_W-1:0]  null_cnt
);
    state_t             r_state;
    logic               r_pc_sel;
    logic               r_flush_if;
    logic               r_nullify_ds;
    logic [ADDR_W-1:0]  r_redirect_pc;
    logic [ADDR_W-1:0]  r_pend_tgt;
    logic [CNT_W-1:0]   r_taken_cnt;
    logic [CNT_W-1:0]   r_null_cnt;

    logic               w_j;
    logic               w_nullify;
    logic [CNT_W-1:0]   w_taken_inc;
    logic [CNT_W-1:0]   w_null_inc;

    branch_seq_ctrl_ch u_ch (
        .i_bl      (bus.BL),
        .i_comb    (bus.COMB),
        .i_comb_tf (bus.COMB_TF),
        .i_cond    (bus.C),
        .i_acc     (bus.ACC),
        .o_j       (w_j)
    );

    // J xor backward covers both COMB cases: forward-taken and backward-not-taken
    assign w_nullify = bus.n_bit & (bus.BL | (bus.COMB & (w_j ^ bus.br_backward)));

    assign w_taken_inc = (r_taken_cnt == '1) ? r_taken_cnt : r_taken_cnt + 1'b1;
    assign w_null_inc  = (r_null_cnt  == '1) ? r_null_cnt  : r_null_cnt  + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_pc_sel      <= 1'b0;
            r_flush_if    <= 1'b0;
            r_nullify_ds  <= 1'b0;
            r_redirect_pc <= '0;
            r_pend_tgt    <= '0;
            r_taken_cnt   <= '0;
            r_null_cnt    <= '0;
        end else if (!stall) begin
            // Outputs are single-cycle pulses unless a state below re-asserts them
            r_pc_sel      <= 1'b0;
            r_flush_if    <= 1'b0;
            r_nullify_ds  <= 1'b0;
            r_redirect_pc <= '0;
            case (r_state)
                S_IDLE: begin
                    if (bus.br_valid) begin
                        if (w_j) begin
                            r_state       <= S_REDIR;
                            r_pc_sel      <= 1'b1;
                            r_flush_if    <= 1'b1;
                            r_redirect_pc <= bus.br_target;
                            r_nullify_ds  <= w_nullify;
                            r_taken_cnt   <= w_taken_inc;
                            if (w_nullify) begin
                                r_null_cnt <= w_null_inc;
                            end
                        end else if (w_nullify) begin
                            r_state      <= S_NULL;
                            r_nullify_ds <= 1'b1;
                            r_null_cnt   <= w_null_inc;
                        end
                    end
                end
                S_REDIR: begin
                    // A live branch in the delay slot gets its target parked for one cycle
                    if (bus.br_valid && !r_nullify_ds && w_j) begin
                        r_state    <= S_PEND;
                        r_pend_tgt <= bus.br_target;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_NULL: begin
                    r_state <= S_IDLE;
                end
                S_PEND: begin
                    r_state       <= S_IDLE;
                    r_pc_sel      <= 1'b1;
                    r_flush_if    <= 1'b1;
                    r_redirect_pc <= r_pend_tgt;
                    r_pend_tgt    <= '0;
                    r_taken_cnt   <= w_taken_inc;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.pc_sel      = r_pc_sel;
    assign bus.flush_if    = r_flush_if;
    assign bus.nullify_ds  = r_nullify_ds;
    assign bus.redirect_pc = r_redirect_pc;
    assign busy            = (r_state != S_IDLE);
    assign taken_cnt       = r_taken_cnt;
    assign null_cnt        = r_null_cnt;

endmodule
`default_nettype wire
